fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write arbiter sharing one bramfifo write port between N_ requesters.
//  Grants one requester at a time for a whole packet (beats up to and including req_last).
//  Applies backpressure from the FIFO fill level so no write is ever dropped.
//  Sits between producer blocks and the bramfifo: drives its we/din and reads its fill.
// PARAMETERS
//  N_      4   number of requesters (>=2)
//  DATA_   8   data width; must equal the FIFO DATA_
//  ADDR_   8   FIFO address width; capacity is 2**ADDR_ entries
// PORTS
//  clk        in   1              clock, all state on posedge
//  rst_       in   1              asynchronous reset, active-low
//  req_valid  in   N_             requester i has a beat on req_data[i]
//  req_data   in   N_ x DATA_     beat data per requester
//  req_last   in   N_             beat is the final beat of requester i's packet
//  req_ready  out  N_             beat of requester i accepted this cycle (valid&ready)
//  fifo_fill  in   ADDR_+1        current FIFO occupancy
//  fifo_we    out  1              FIFO write enable
//  fifo_din   out  DATA_          FIFO write data
//  grant      out  N_             one-hot current owner, all-zero in IDLE
//  busy       out  1              high in GRANT state
// BEHAVIOUR
//  - Reset (async, rst_ low): state=IDLE, ptr=0, grant=0, busy=0; outputs req_ready=0,
//    fifo_we=0, fifo_din=0 combinationally while in IDLE. Reset mid-packet abandons it.
//  - FSM, 2 states. IDLE: if any req_valid, pick first i with req_valid[i] searching
//    ptr, ptr+1, ... wrapping mod N_; register grant=onehot(i), go GRANT. Else stay.
//  - Arbitration latency: 1 cycle (request seen in IDLE -> first possible beat next cycle).
//  - GRANT (owner g): space = (fifo_fill < 2**ADDR_). req_ready[g] = space (comb.),
//    other req_ready bits 0. Beat transfers when req_valid[g] & req_ready[g]:
//    fifo_we=1, fifo_din=req_data[g] same cycle (zero-latency pass-through).
//  - No transfer -> fifo_we=0, fifo_din=0. Owner dropping valid mid-packet keeps grant.
//  - Transfer with req_last[g]=1: next state IDLE, ptr = (g+1) mod N_ (wraps N_-1 -> 0).
//  - Exactly one IDLE cycle between packets, even if the same/other requester is valid.
//  - Full: fifo_fill == 2**ADDR_ -> req_ready all 0, fifo_we 0, grant held indefinitely.
//  - Simultaneous FIFO read while full: ignored this cycle (fill is the sole source of
//    truth; write allowed from the cycle fill drops below 2**ADDR_).
//  - fifo_fill > 2**ADDR_ is illegal; treated as full. Assertion flags it in simulation.
//  - ptr width $clog2(N_); ptr only changes on packet end or reset.
//  - Invariants: grant is onehot0; fifo_we implies busy; at most one req_ready bit set.
// STRUCTURE
//  - Shared package fifo_arb_pkg: typedef enum logic {IDLE, GRANT} arb_state_t;
//    function onehot_idx for encoding/decoding grant.
//  - Sub-module rr_pick #(N_): combinational, inputs req[N_], ptr; outputs onehot
//    pick and any. Reused by other round-robin schedulers in UTILS.
//  - Top: FSM + ptr register + grant register + output mux (AND-OR over grant).
// TESTING
//  - Reset: rst_=0 with all req_valid=1 -> grant=0, fifo_we=0, req_ready=0, busy=0.
//  - Round robin: all 4 valid, 1-beat packets (last=1), fill=0 -> grants 0,1,2,3,0
//    each GRANT cycle separated by one IDLE cycle; fifo_din follows owner data.
//  - Packet lock: req0 sends 3 beats (last on 3rd) with valid gap at beat 2, req1 valid
//    throughout -> grant stays 0001 for all 3 beats; req1 granted only after.
//  - Full: fill=256 (ADDR_=8) in GRANT, owner valid -> req_ready=0, fifo_we=0 for
//    5 cycles; fill=255 -> beat written same cycle.
//  - Wrap/skip: ptr=3, only req1 valid -> req1 granted; after its last beat ptr=2.
//  - Reset mid-packet: assert rst_ during beat 2 of 4 -> IDLE, ptr=0, no further writes.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the bramfifo write arbiter and related
// round-robin schedulers.
//   arb_state_t : two-state arbiter FSM encoding (IDLE, GRANT)
//   onehot_idx  : index of the set bit in a one-hot vector (highest wins if
//                 more than one is set; zero for an all-zero vector)
package fifo_arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  function automatic int unsigned onehot_idx(input logic [31:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (v[i[4:0]]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req  [N_]  : request vector
//   ptr  [PW]  : highest-priority index; search order ptr, ptr+1, ... mod N_
//   pick [N_]  : one-hot winner, all-zero when nothing requests
//   any        : at least one request present
module rr_pick #(
  parameter  int N_ = 4,
  localparam int PW = (N_ > 1) ? $clog2(N_) : 1
) (
  input  logic [N_-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [N_-1:0] pick,
  output logic          any
);

  localparam int SW = PW + 1;

  logic [SW-1:0] pos;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    pos  = '0;
    for (int unsigned k = 0; k < N_; k++) begin
      // ptr + k stays below 2*N_, so a single conditional subtract is the modulo.
      pos = {1'b0, ptr} + SW'(k);
      if (pos >= SW'(N_)) pos = pos - SW'(N_);
      if (!any && req[pos[PW-1:0]]) begin
        pick[pos[PW-1:0]] = 1'b1;
        any               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one bramfifo write port between N_
// requesters. A requester owns the port for a whole packet (through the beat
// carrying req_last); writes are throttled by the FIFO fill level so no beat
// is ever dropped.
//   clk, rst_            : clock, asynchronous active-low reset
//   req_valid/data/last  : per-requester beat handshake inputs
//   req_ready            : per-requester accept (only the owner, only with space)
//   fifo_fill            : FIFO occupancy, 0 .. 2**ADDR_
//   fifo_we, fifo_din    : FIFO write port, zero-latency pass-through of owner beat
//   grant                : one-hot owner, all-zero in IDLE
//   busy                 : high while a packet owns the port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_    = 4,
  parameter int DATA_ = 8,
  parameter int ADDR_ = 8
) (
  input  logic                      clk,
  input  logic                      rst_,
  input  logic [N_-1:0]             req_valid,
  input  logic [N_-1:0][DATA_-1:0]  req_data,
  input  logic [N_-1:0]             req_last,
  output logic [N_-1:0]             req_ready,
  input  logic [ADDR_:0]            fifo_fill,
  output logic                      fifo_we,
  output logic [DATA_-1:0]          fifo_din,
  output logic [N_-1:0]             grant,
  output logic                      busy
);

  localparam int            PW   = (N_ > 1) ? $clog2(N_) : 1;
  localparam logic [ADDR_:0] FULL = {1'b1, {ADDR_{1'b0}}};

  arb_state_t    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] next_ptr;
  logic [N_-1:0] pick;
  logic          any;
  logic          space;
  logic          xfer;
  logic          last;

  rr_pick #(.N_(N_)) u_pick (
    .req  (req_valid),
    .ptr  (ptr),
    .pick (pick),
    .any  (any)
  );

  // grant is all-zero in IDLE, so every grant-qualified output is naturally
  // idle there; illegal fill values above FULL also read as "no space".
  always_comb begin
    space     = (fifo_fill < FULL);
    req_ready = grant & {N_{space}};
    xfer      = |(req_valid & req_ready);
    last      = |(grant & req_last);
    fifo_we   = xfer;
    fifo_din  = '0;
    for (int unsigned i = 0; i < N_; i++) begin
      fifo_din = fifo_din |
                 (req_data[i[PW-1:0]] & {DATA_{xfer & grant[i[PW-1:0]]}});
    end
    gidx     = PW'(onehot_idx(32'(grant)));
    next_ptr = (gidx == PW'(N_ - 1)) ? '0 : gidx + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state <= GRANT;
            grant <= pick;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (xfer && last) begin
            state <= IDLE;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= next_ptr;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  a_fill_legal:   assert property (@(posedge clk) disable iff (!rst_) fifo_fill <= FULL);
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_) $onehot0(grant));
  a_we_busy:      assert property (@(posedge clk) disable iff (!rst_) fifo_we |-> busy);
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_) $onehot0(req_ready));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  logic            clk = 1'b0;
  logic            rst_ = 1'b0;
  logic [3:0]      vld = '0;
  logic [3:0][7:0] dat = '0;
  logic [3:0]      lst = '0;
  logic [3:0]      req_ready;
  logic [8:0]      fill = '0;
  logic            fifo_we;
  logic [7:0]      fifo_din;
  logic [3:0]      grant;
  logic            busy;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_(4), .DATA_(8), .ADDR_(8)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .req_valid (vld),
    .req_data  (dat),
    .req_last  (lst),
    .req_ready (req_ready),
    .fifo_fill (fill),
    .fifo_we   (fifo_we),
    .fifo_din  (fifo_din),
    .grant     (grant),
    .busy      (busy)
  );

  // Scoreboard: every FIFO write must match the oldest expected beat.
  always @(negedge clk) begin
    logic [7:0] e;
    if (fifo_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_write t=%0t din got %h want no write", $time, fifo_din);
      end else begin
        e = exp_q.pop_front();
        if (fifo_din !== e) begin
          miscompares++;
          $display("FAIL sb_write_data t=%0t din got %h want %h", $time, fifo_din, e);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_ = 1'b0; vld = '0; lst = '0; fill = '0;
    cyc(); cyc();
    rst_ = 1'b1;
  endtask

  task automatic test_reset();
    rst_ = 1'b0; vld = 4'b1111; lst = 4'b1111; fill = '0;
    dat  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    for (int c = 0; c < 3; c++) begin
      cyc();
      #1;
      vectors++;
      if ({grant, busy, fifo_we, req_ready} !== 10'b0) begin
        miscompares++;
        $display("FAIL reset_outputs c%0d {grant,busy,we,ready} got %b want %b",
                 c, {grant, busy, fifo_we, req_ready}, 10'b0);
      end
      vectors++;
      if (fifo_din !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_din c%0d got %h want 00", c, fifo_din);
      end
    end
    vld = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic [7:0] ed;
    int         o;
    apply_reset();
    vld = 4'b1111; lst = 4'b1111;
    dat = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    for (int k = 0; k < 10; k++) begin
      #1;
      o  = (k / 2) % 4;
      eg = (k % 2 == 1) ? (4'b0001 << o) : 4'b0000;
      ed = (k % 2 == 1) ? dat[o] : 8'h00;
      if (k % 2 == 1) exp_q.push_back(ed);
      vectors++;
      if ({grant, busy, fifo_we, req_ready} !== {eg, |eg, |eg, eg}) begin
        miscompares++;
        $display("FAIL rr_state k%0d {grant,busy,we,ready} got %b want %b",
                 k, {grant, busy, fifo_we, req_ready}, {eg, |eg, |eg, eg});
      end
      vectors++;
      if (fifo_din !== ed) begin
        miscompares++;
        $display("FAIL rr_din k%0d got %h want %h", k, fifo_din, ed);
      end
      cyc();
    end
    vld = '0;
  endtask

  task automatic test_packet_lock();
    logic [3:0] t_vld [8] = '{4'b0011, 4'b0011, 4'b0010, 4'b0011,
                              4'b0011, 4'b0010, 4'b0010, 4'b0000};
    logic [3:0] t_lst [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010,
                              4'b0011, 4'b0010, 4'b0010, 4'b0000};
    logic [7:0] t_d0  [8] = '{8'h10, 8'h11, 8'h1F, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    logic [9:0] t_exp [8] = '{10'b0000_0_0_0000, 10'b0001_1_1_0001, 10'b0001_1_0_0001,
                              10'b0001_1_1_0001, 10'b0001_1_1_0001, 10'b0000_0_0_0000,
                              10'b0010_1_1_0010, 10'b0000_0_0_0000};
    logic [7:0] t_wd  [8] = '{8'h00, 8'h11, 8'h00, 8'h12, 8'h13, 8'h00, 8'h21, 8'h00};
    apply_reset();
    dat[1] = 8'h21;
    for (int c = 0; c < 8; c++) begin
      vld = t_vld[c]; lst = t_lst[c]; dat[0] = t_d0[c];
      #1;
      if (t_exp[c][4]) exp_q.push_back(t_wd[c]);
      vectors++;
      if ({grant, busy, fifo_we, req_ready} !== t_exp[c]) begin
        miscompares++;
        $display("FAIL lock_state c%0d {grant,busy,we,ready} got %b want %b",
                 c, {grant, busy, fifo_we, req_ready}, t_exp[c]);
      end
      vectors++;
      if (fifo_din !== t_wd[c]) begin
        miscompares++;
        $display("FAIL lock_din c%0d got %h want %h", c, fifo_din, t_wd[c]);
      end
      cyc();
    end
  endtask

  task automatic test_full();
    logic [9:0] e;
    apply_reset();
    vld = 4'b0001; lst = 4'b0000; dat[0] = 8'h55; fill = 9'd256;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) begin fill = 9'd255; lst = 4'b0001; end
      if (c == 7) begin vld = '0; fill = '0; end
      #1;
      if (c == 0 || c == 7) e = 10'b0000_0_0_0000;
      else if (c == 6)      e = 10'b0001_1_1_0001;
      else                  e = 10'b0001_1_0_0000;
      if (e[4]) exp_q.push_back(8'h55);
      vectors++;
      if ({grant, busy, fifo_we, req_ready} !== e) begin
        miscompares++;
        $display("FAIL full_state c%0d fill %0d {grant,busy,we,ready} got %b want %b",
                 c, fill, {grant, busy, fifo_we, req_ready}, e);
      end
      cyc();
    end
  endtask

  task automatic test_wrap_skip();
    logic [3:0] t_vld [7] = '{4'b0100, 4'b0100, 4'b0010, 4'b0010,
                              4'b1111, 4'b1111, 4'b0000};
    logic [9:0] t_exp [7] = '{10'b0000_0_0_0000, 10'b0100_1_1_0100, 10'b0000_0_0_0000,
                              10'b0010_1_1_0010, 10'b0000_0_0_0000, 10'b0100_1_1_0100,
                              10'b0000_0_0_0000};
    logic [7:0] t_wd  [7] = '{8'h00, 8'h22, 8'h00, 8'h21, 8'h00, 8'h22, 8'h00};
    apply_reset();
    dat = {8'h33, 8'h22, 8'h21, 8'h20};
    for (int c = 0; c < 7; c++) begin
      vld = t_vld[c]; lst = t_vld[c];
      #1;
      if (t_exp[c][4]) exp_q.push_back(t_wd[c]);
      vectors++;
      if ({grant, busy, fifo_we, req_ready} !== t_exp[c]) begin
        miscompares++;
        $display("FAIL wrap_state c%0d {grant,busy,we,ready} got %b want %b",
                 c, {grant, busy, fifo_we, req_ready}, t_exp[c]);
      end
      vectors++;
      if (fifo_din !== t_wd[c]) begin
        miscompares++;
        $display("FAIL wrap_din c%0d got %h want %h", c, fifo_din, t_wd[c]);
      end
      cyc();
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [3:0] t_vld [9] = '{4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0001,
                              4'b0001, 4'b1111, 4'b1111, 4'b0000};
    logic [3:0] t_lst [9] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000,
                              4'b0000, 4'b1111, 4'b1111, 4'b0000};
    logic       t_rst [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [9:0] t_exp [9] = '{10'b0000_0_0_0000, 10'b0010_1_1_0010, 10'b0000_0_0_0000,
                              10'b0001_1_1_0001, 10'b0000_0_0_0000, 10'b0000_0_0_0000,
                              10'b0000_0_0_0000, 10'b0001_1_1_0001, 10'b0000_0_0_0000};
    logic [7:0] t_wd  [9] = '{8'h00, 8'h21, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00};
    apply_reset();
    dat = {8'h33, 8'h22, 8'h21, 8'h20};
    for (int c = 0; c < 9; c++) begin
      vld = t_vld[c]; lst = t_lst[c]; rst_ = t_rst[c];
      #1;
      if (t_exp[c][4]) exp_q.push_back(t_wd[c]);
      vectors++;
      if ({grant, busy, fifo_we, req_ready} !== t_exp[c]) begin
        miscompares++;
        $display("FAIL midrst_state c%0d {grant,busy,we,ready} got %b want %b",
                 c, {grant, busy, fifo_we, req_ready}, t_exp[c]);
      end
      vectors++;
      if (fifo_din !== t_wd[c]) begin
        miscompares++;
        $display("FAIL midrst_din c%0d got %h want %h", c, fifo_din, t_wd[c]);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_full();
    test_wrap_skip();
    test_reset_mid_packet();
    cyc(); cyc();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain pending beats got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
